// File: rtl/conv2d_window_pkg.sv
// conv2d_window_pkg: shared constants and FSM encoding for the 3x3 window generator
//   BIT_DATA        default pixel width
//   CONV2D_WIN_SIDE window side length (3)
//   CONV2D_KSIZE    taps per window (CONV2D_WIN_SIDE squared)
//   state_t         FILL (rows 0..1 being buffered) / STREAM (rows >= 2)
package conv2d_window_pkg;
   localparam int BIT_DATA = 8;
   localparam int CONV2D_WIN_SIDE = 3;
   localparam int CONV2D_KSIZE = CONV2D_WIN_SIDE * CONV2D_WIN_SIDE;
   typedef enum logic {FILL, STREAM} state_t;
endpackage

// File: rtl/conv2d_window_if.sv
// conv2d_window_if: pixel stream in, window bus out
//   in_valid/in_sof/in_data          pixel source -> window generator
//   win/win_valid/win_row/win_col    window generator -> kernel MAC
//   frame_done                       end-of-frame pulse
//   master: pixel source side; slave: window generator side
interface conv2d_window_if import conv2d_window_pkg::*; #(
   parameter int DATA_W = BIT_DATA,
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
);
   logic in_valid;
   logic in_sof;
   logic signed [DATA_W-1:0] in_data;
   logic [DATA_W*CONV2D_KSIZE-1:0] win;
   logic win_valid;
   logic [$clog2(IMG_H)-1:0] win_row;
   logic [$clog2(IMG_W)-1:0] win_col;
   logic frame_done;
   modport master(output in_valid, in_sof, in_data, input win, win_valid, win_row, win_col, frame_done);
   modport slave(input in_valid, in_sof, in_data, output win, win_valid, win_row, win_col, frame_done);
endinterface

// File: rtl/conv2d_line_buffer.sv
// conv2d_line_buffer: one image row of pixels, written at addr, read combinationally at addr
//   clock  system clock
//   we     write din at addr
//   addr   column address
//   din    pixel to store
//   dout   pixel currently stored at addr (value before this cycle's write)
module conv2d_line_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH = 28
) (
   input  logic                     clock,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clock)
      if (we) mem[addr] <= din;
   assign dout = mem[addr];
endmodule

// File: rtl/conv2d_window.sv
// conv2d_window: streaming 3x3 window generator for raster-order pixels
//   clock   system clock, rising edge
//   reset   asynchronous, active-high
//   bus     conv2d_window_if.slave: in_valid/in_sof/in_data in, win/win_valid/win_row/win_col/frame_done out
//   Build option: CONV2D_WINDOW_STRIDE2_EN emits only windows whose (r-2),(c-2) are both even
module conv2d_window import conv2d_window_pkg::*; #(
   parameter int DATA_W = BIT_DATA,
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
) (
   input logic clock,
   input logic reset,
   conv2d_window_if.slave bus
);
   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);
   localparam int WW = DATA_W * CONV2D_KSIZE;
   state_t st, st_n;
   logic [RW-1:0] r, pr, r_n, row_n;
   logic [CW-1:0] c, pc, c_n, col_n;
   logic [DATA_W-1:0] q0, q1;
   logic [DATA_W-1:0] px [CONV2D_WIN_SIDE];
   logic [WW-1:0] win_q, win_n;
   logic acc, last_col, last_row, valid_n;
   assign acc = bus.in_valid;
   // in_sof pins the current pixel to (0,0) whatever the counters say
   assign pr = bus.in_sof ? '0 : r;
   assign pc = bus.in_sof ? '0 : c;
   conv2d_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
      .clock(clock), .we(acc), .addr(pc), .din(bus.in_data), .dout(q0)
   );
   conv2d_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
      .clock(clock), .we(acc), .addr(pc), .din(q0), .dout(q1)
   );
   always_comb begin
      last_col = pc == CW'(IMG_W - 1);
      last_row = pr == RW'(IMG_H - 1);
      c_n = last_col ? '0 : pc + 1'b1;
      r_n = last_col ? (last_row ? '0 : pr + 1'b1) : pr;
      st_n = st;
      if (acc) st_n = (bus.in_sof || (last_row && last_col)) ? FILL : (pr == RW'(2)) ? STREAM : st;
      // STREAM is entered at (2,0); columns 0..1 of each row are still excluded by pc >= 2
      valid_n = acc && !bus.in_sof && st == STREAM && pc >= CW'(2);
`ifdef CONV2D_WINDOW_STRIDE2_EN
      valid_n = valid_n && !pr[0] && !pc[0];
      row_n = (pr - RW'(2)) >> 1;
      col_n = (pc - CW'(2)) >> 1;
`else
      row_n = pr - RW'(2);
      col_n = pc - CW'(2);
`endif
      // each row of taps shifts toward kx=0; the new right column is {lb1, lb0, in_data}
      px[0] = q1;
      px[1] = q0;
      px[2] = bus.in_data;
      win_n = '0;
      for (int k = 0; k < CONV2D_WIN_SIDE; k++)
         win_n[3*DATA_W*k +: 3*DATA_W] = {px[k], win_q[3*DATA_W*k+DATA_W +: 2*DATA_W]};
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) st <= FILL;
      else st <= st_n;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         r <= '0;
         c <= '0;
         win_q <= '0;
         bus.win_valid <= 1'b0;
         bus.win_row <= '0;
         bus.win_col <= '0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.win_valid <= valid_n;
         bus.frame_done <= acc && last_row && last_col;
         if (acc) begin
            r <= r_n;
            c <= c_n;
            win_q <= win_n;
         end
         if (valid_n) begin
            bus.win_row <= row_n;
            bus.win_col <= col_n;
         end
      end
   assign bus.win = win_q;
endmodule

// File: tb/tb_conv2d_window.sv
// tb_conv2d_window: directed checks of conv2d_window on a 5x5 frame of pixels 5r+c
module tb_conv2d_window;
   localparam int DW = 8;
   localparam int N = 5;
   localparam int WW = DW * 9;
   typedef struct {int row; int col; int tap0;} exp_t;
   typedef struct {int row; int col; logic [WW-1:0] win; logic fd;} got_t;
`ifdef CONV2D_WINDOW_STRIDE2_EN
   localparam int NW = 4;
`else
   localparam int NW = 9;
`endif
   logic clock = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   int consec = 0;
   int fd_alone = 0;
   logic prev_v = 1'b0;
   exp_t tbl [NW];
   got_t got [$];
   conv2d_window_if #(.DATA_W(DW), .IMG_W(N), .IMG_H(N)) bus ();
   conv2d_window #(.DATA_W(DW), .IMG_W(N), .IMG_H(N)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   always @(negedge clock) begin
      if (bus.win_valid) got.push_back('{int'(bus.win_row), int'(bus.win_col), bus.win, bus.frame_done});
      if (bus.win_valid && prev_v) consec++;
      if (bus.frame_done && !bus.win_valid) fd_alone++;
      prev_v = bus.win_valid;
   end
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask
   function automatic logic [WW-1:0] exp_win(input int t0);
      logic [WW-1:0] v;
      for (int i = 0; i < 9; i++) v[DW*i +: DW] = DW'(t0 + N * (i / 3) + i % 3);
      return v;
   endfunction
   task automatic send(input int pix, input logic sof);
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_sof = sof;
      bus.in_data = DW'(pix);
      @(posedge clock);
      #1;
   endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         bus.in_valid = 1'b0;
         bus.in_sof = 1'b0;
         @(posedge clock);
         #1;
      end
   endtask
   task automatic send_frame(input logic sof, input logic gaps);
      for (int p = 0; p < N * N; p++) begin
         send(p, sof && p == 0);
         if (gaps) idle(1);
      end
      idle(3);
   endtask
   task automatic check_frame(input string tag);
      chk({tag, " count"}, 128'(got.size()), 128'(NW));
      for (int k = 0; k < NW && k < got.size(); k++) begin
         chk($sformatf("%s w%0d row", tag, k), 128'(got[k].row), 128'(tbl[k].row));
         chk($sformatf("%s w%0d col", tag, k), 128'(got[k].col), 128'(tbl[k].col));
         chk($sformatf("%s w%0d taps", tag, k), 128'(got[k].win), 128'(exp_win(tbl[k].tap0)));
         chk($sformatf("%s w%0d frame_done", tag, k), 128'(got[k].fd), 128'(k == NW - 1));
      end
      chk({tag, " frame_done without window"}, 128'(fd_alone), 128'(0));
   endtask
   initial begin
      int s;
`ifdef CONV2D_WINDOW_STRIDE2_EN
      tbl = '{'{0, 0, 0}, '{0, 1, 2}, '{1, 0, 10}, '{1, 1, 12}};
`else
      tbl = '{'{0, 0, 0}, '{0, 1, 1}, '{0, 2, 2}, '{1, 0, 5}, '{1, 1, 6}, '{1, 2, 7},
              '{2, 0, 10}, '{2, 1, 11}, '{2, 2, 12}};
`endif
      bus.in_valid = 1'b0;
      bus.in_sof = 1'b0;
      bus.in_data = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset win", 128'(bus.win), 128'(0));
      chk("reset win_valid", 128'(bus.win_valid), 128'(0));
      chk("reset win_row", 128'(bus.win_row), 128'(0));
      chk("reset win_col", 128'(bus.win_col), 128'(0));
      chk("reset frame_done", 128'(bus.frame_done), 128'(0));
      reset = 1'b0;
      idle(2);
      got.delete();
      for (int p = 0; p < 12; p++) send(p, p == 0);
      chk("no window before pixel 12", 128'(got.size() + int'(bus.win_valid)), 128'(0));
      send(12, 1'b0);
      chk("window after pixel 12", 128'(bus.win_valid), 128'(1));
      for (int p = 13; p < N * N; p++) send(p, 1'b0);
      idle(3);
      check_frame("continuous");
      if (got.size() > 0) begin
         s = 0;
         for (int i = 0; i < 9; i++) s += int'(got[0].win[DW*i +: DW]);
         chk("first window sum", 128'(s), 128'(54));
      end
      got.delete();
      consec = 0;
      send_frame(1'b1, 1'b1);
      check_frame("gapped");
      chk("gapped consecutive win_valid", 128'(consec), 128'(0));
      got.delete();
      for (int p = 0; p < 7; p++) send(p + 100, p == 0);
      idle(2);
      chk("aborted frame windows", 128'(got.size()), 128'(0));
      send_frame(1'b1, 1'b0);
      check_frame("resync");
      for (int p = 0; p < 18; p++) send(p, p == 0);
      chk("pre-reset win nonzero", 128'(bus.win != '0), 128'(1));
`ifdef CONV2D_WINDOW_STRIDE2_EN
      chk("pre-reset win_valid", 128'(bus.win_valid), 128'(0));
`else
      chk("pre-reset win_valid", 128'(bus.win_valid), 128'(1));
`endif
      #1 reset = 1'b1;
      #1;
      chk("async reset win", 128'(bus.win), 128'(0));
      chk("async reset win_valid", 128'(bus.win_valid), 128'(0));
      chk("async reset win_row", 128'(bus.win_row), 128'(0));
      chk("async reset win_col", 128'(bus.win_col), 128'(0));
      chk("async reset frame_done", 128'(bus.frame_done), 128'(0));
      bus.in_valid = 1'b0;
      @(posedge clock);
      #2 reset = 1'b0;
      got.delete();
      send_frame(1'b0, 1'b0);
      check_frame("after reset");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
